// File: rtl/jts16_gfx_slot.sv
// SDRAM-side responder for one S16 video layer port: serves addr/ok/data from a
// one-entry cache and refills it through the shared SDRAM req/ack/dst handshake.
module jts16_gfx_slot #(
  parameter int              AW   = 13,
  parameter int              DW   = 32,
  parameter int              SAW  = 22,
  parameter logic [SAW-1:0]  BASE = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slot_cs,
  input  logic [AW-1:0]   slot_addr,
  output logic            slot_ok,
  output logic [DW-1:0]   slot_dout,
  output logic            sdram_req,
  output logic [SAW-1:0]  sdram_addr,
  input  logic            sdram_ack,
  input  logic            sdram_dst,
  input  logic [15:0]     sdram_din
);

  localparam int SHIFT = (DW == 32) ? 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA
  } state_t;

  state_t          r_state;
  logic            r_valid;
  logic [AW-1:0]   r_cache_addr;
  logic [AW-1:0]   r_fetch_addr;
  logic [DW-1:0]   r_dout;
  logic            r_req;
  logic [SAW-1:0]  r_sdram_addr;
  logic            r_beat;

  logic            w_miss;
  logic            w_last;
  logic [SAW-1:0]  w_word_addr;
  logic [SAW-1:0]  w_sdram_addr;
  logic [DW-1:0]   w_dout_next;

  // Zero-extended, word-scaled address; the sum wraps modulo 2^SAW.
  always_comb begin
    w_word_addr  = SAW'(slot_addr) << SHIFT;
    w_sdram_addr = BASE + w_word_addr;
  end

  generate
    if (DW == 32) begin : g_dw32
      assign w_dout_next = r_beat ? {sdram_din, r_dout[15:0]}
                                  : {r_dout[31:16], sdram_din};
      assign w_last      = r_beat;
    end else begin : g_dw16
      assign w_dout_next = sdram_din;
      assign w_last      = 1'b1;
    end
  endgenerate

  assign w_miss     = !r_valid || (slot_addr != r_cache_addr);
  // Combinational so an address change hides stale data in the same cycle.
  assign slot_ok    = slot_cs && r_valid && (slot_addr == r_cache_addr);
  assign slot_dout  = r_dout;
  assign sdram_req  = r_req;
  assign sdram_addr = r_sdram_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_valid      <= 1'b0;
      r_cache_addr <= '0;
      r_fetch_addr <= '0;
      r_dout       <= '0;
      r_req        <= 1'b0;
      r_sdram_addr <= '0;
      r_beat       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (slot_cs && w_miss) begin
            r_fetch_addr <= slot_addr;
            r_valid      <= 1'b0;
            r_req        <= 1'b1;
            r_sdram_addr <= w_sdram_addr;
            r_state      <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            r_req   <= 1'b0;
            r_beat  <= 1'b0;
            r_state <= DATA;
          end
        end
        DATA: begin
          // The fetch always completes under fetch_addr, even if the layer moved on.
          if (sdram_dst) begin
            r_dout <= w_dout_next;
            if (w_last) begin
              r_cache_addr <= r_fetch_addr;
              r_valid      <= 1'b1;
              r_state      <= IDLE;
            end else begin
              r_beat <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
